// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - two-port branch-resolve FIFO draining up to two local-predictor updates per cycle
// Define BP_UPD_CONFLICT_SERIALIZE_EN to hold back slot 2 when head and head+1 share a local-table index.
module bp_update_sched #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       res1_valid,
  input  logic [63:0]                res1_pc,
  input  logic                       res1_taken,
  input  logic                       res2_valid,
  input  logic [63:0]                res2_pc,
  input  logic                       res2_taken,
  output logic                       enq_ready,
  output logic [$clog2(DEPTH):0]     q_count,
  output logic                       drop_err,
  output logic                       branch_valid1,
  output logic [63:0]                branch_pc1,
  output logic                       branch_result1,
  output logic                       branch_valid2,
  output logic [63:0]                branch_pc2,
  output logic                       branch_result2
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef BP_UPD_CONFLICT_SERIALIZE_EN
  localparam bit SERIALIZE = 1'b1;
`else
  localparam bit SERIALIZE = 1'b0;
`endif

  logic [63:0]      pc_mem_q [DEPTH];
  logic [63:0]      pc_mem_d [DEPTH];
  logic [DEPTH-1:0] tk_mem_q, tk_mem_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_q, drop_d;
  logic             bv1_q, bv1_d, bv2_q, bv2_d;
  logic [63:0]      bpc1_q, bpc1_d, bpc2_q, bpc2_d;
  logic             br1_q, br1_d, br2_q, br2_d;

  logic [PTR_W-1:0] head_nxt, wptr;
  logic [CNT_W-1:0] n_enq, n_deq;
  logic             same_idx, ready, issue1, issue2;

  assign head_nxt = head_q + PTR_W'(1);
  assign same_idx = pc_mem_q[head_q][IDX_W+1:2] == pc_mem_q[head_nxt][IDX_W+1:2];
  // Space check uses only the registered count so enq_ready stays a clean flop decode.
  assign ready    = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);
  assign issue1   = count_q != '0;
  assign issue2   = (count_q >= CNT_W'(2)) && !(SERIALIZE && same_idx);

  always_comb begin
    pc_mem_d = pc_mem_q;
    tk_mem_d = tk_mem_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    drop_d   = drop_q;
    bv1_d    = 1'b0;
    bv2_d    = 1'b0;
    bpc1_d   = bpc1_q;
    bpc2_d   = bpc2_q;
    br1_d    = br1_q;
    br2_d    = br2_q;
    wptr     = tail_q;
    n_enq    = '0;
    n_deq    = '0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      drop_d  = 1'b0;
    end else begin
      if (issue1) begin
        bv1_d  = 1'b1;
        bpc1_d = pc_mem_q[head_q];
        br1_d  = tk_mem_q[head_q];
        n_deq  = CNT_W'(1);
      end
      if (issue2) begin
        bv2_d  = 1'b1;
        bpc2_d = pc_mem_q[head_nxt];
        br2_d  = tk_mem_q[head_nxt];
        n_deq  = CNT_W'(2);
      end
      // Port 1 is older, so it takes the first free slot.
      if (ready) begin
        if (res1_valid) begin
          pc_mem_d[wptr] = res1_pc;
          tk_mem_d[wptr] = res1_taken;
          wptr           = wptr + PTR_W'(1);
          n_enq          = n_enq + CNT_W'(1);
        end
        if (res2_valid) begin
          pc_mem_d[wptr] = res2_pc;
          tk_mem_d[wptr] = res2_taken;
          wptr           = wptr + PTR_W'(1);
          n_enq          = n_enq + CNT_W'(1);
        end
      end else if (res1_valid || res2_valid) begin
        drop_d = 1'b1;
      end
      head_d  = head_q + n_deq[PTR_W-1:0];
      tail_d  = wptr;
      count_d = count_q + n_enq - n_deq;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pc_mem_q[i] <= '0;
      tk_mem_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
      bv1_q    <= 1'b0;
      bv2_q    <= 1'b0;
      bpc1_q   <= '0;
      bpc2_q   <= '0;
      br1_q    <= 1'b0;
      br2_q    <= 1'b0;
    end else begin
      pc_mem_q <= pc_mem_d;
      tk_mem_q <= tk_mem_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      bv1_q    <= bv1_d;
      bv2_q    <= bv2_d;
      bpc1_q   <= bpc1_d;
      bpc2_q   <= bpc2_d;
      br1_q    <= br1_d;
      br2_q    <= br2_d;
    end
  end

  assign enq_ready      = ready;
  assign q_count        = count_q;
  assign drop_err       = drop_q;
  assign branch_valid1  = bv1_q;
  assign branch_pc1     = bpc1_q;
  assign branch_result1 = br1_q;
  assign branch_valid2  = bv2_q;
  assign branch_pc2     = bpc2_q;
  assign branch_result2 = br2_q;
endmodule

// File: tb/tb_bp_update_sched.sv
// tb/tb_bp_update_sched.sv - directed scoreboard bench for bp_update_sched
module tb_bp_update_sched;
  logic        clock, reset, flush;
  logic        res1_valid, res1_taken, res2_valid, res2_taken;
  logic [63:0] res1_pc, res2_pc;
  logic        enq_ready, drop_err;
  logic [3:0]  q_count;
  logic        branch_valid1, branch_result1, branch_valid2, branch_result2;
  logic [63:0] branch_pc1, branch_pc2;

  typedef struct packed {
    logic [63:0] pc;
    logic        taken;
  } upd_t;

  upd_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  bp_update_sched #(.DEPTH(8), .IDX_W(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .res1_valid(res1_valid), .res1_pc(res1_pc), .res1_taken(res1_taken),
    .res2_valid(res2_valid), .res2_pc(res2_pc), .res2_taken(res2_taken),
    .enq_ready(enq_ready), .q_count(q_count), .drop_err(drop_err),
    .branch_valid1(branch_valid1), .branch_pc1(branch_pc1), .branch_result1(branch_result1),
    .branch_valid2(branch_valid2), .branch_pc2(branch_pc2), .branch_result2(branch_result2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0;
    res1_valid = 1'b0; res1_pc = 64'h0; res1_taken = 1'b0;
    res2_valid = 1'b0; res2_pc = 64'h0; res2_taken = 1'b0;
  endtask

  task automatic drive(input logic v1, input logic [63:0] p1, input logic t1,
                       input logic v2, input logic [63:0] p2, input logic t2,
                       input logic accept);
    upd_t e;
    res1_valid = v1; res1_pc = p1; res1_taken = t1;
    res2_valid = v2; res2_pc = p2; res2_taken = t2;
    if (accept && v1) begin e.pc = p1; e.taken = t1; sb.push_back(e); end
    if (accept && v2) begin e.pc = p2; e.taken = t2; sb.push_back(e); end
  endtask

  task automatic score();
    upd_t e;
    if (branch_valid2 && !branch_valid1) chk("slot2_without_slot1", 64'(branch_valid1), 64'd1);
    if (branch_valid1) begin
      if (sb.size() == 0) chk("sb_slot1_unexpected", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("sb_slot1_pc", branch_pc1, e.pc);
        chk("sb_slot1_res", 64'(branch_result1), 64'(e.taken));
      end
    end
    if (branch_valid2) begin
      if (sb.size() == 0) chk("sb_slot2_unexpected", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("sb_slot2_pc", branch_pc2, e.pc);
        chk("sb_slot2_res", 64'(branch_result2), 64'(e.taken));
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clear_inputs();
    score();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_enq_ready"}, 64'(enq_ready), 64'd1);
    chk({tag, "_q_count"}, 64'(q_count), 64'd0);
    chk({tag, "_drop_err"}, 64'(drop_err), 64'd0);
    chk({tag, "_bv1"}, 64'(branch_valid1), 64'd0);
    chk({tag, "_bv2"}, 64'(branch_valid2), 64'd0);
    chk({tag, "_bpc1"}, branch_pc1, 64'd0);
    chk({tag, "_bpc2"}, branch_pc2, 64'd0);
    chk({tag, "_br1"}, 64'(branch_result1), 64'd0);
    chk({tag, "_br2"}, 64'(branch_result2), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #12;
    chk_reset_vals("por");
    @(negedge clock);
    reset = 1'b0;

    // single entry latency
    drive(1'b1, 64'h100, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    tick();
    chk("single_cnt_n", 64'(q_count), 64'd1);
    chk("single_bv1_n", 64'(branch_valid1), 64'd0);
    tick();
    chk("single_bv1", 64'(branch_valid1), 64'd1);
    chk("single_pc1", branch_pc1, 64'h100);
    chk("single_res1", 64'(branch_result1), 64'd1);
    chk("single_bv2", 64'(branch_valid2), 64'd0);
    chk("single_cnt", 64'(q_count), 64'd0);
    tick();
    chk("single_bv1_after", 64'(branch_valid1), 64'd0);
    chk("single_pc1_held", branch_pc1, 64'h100);

    // dual, distinct indices
    drive(1'b1, 64'h100, 1'b0, 1'b1, 64'h104, 1'b1, 1'b1);
    tick();
    chk("dual_cnt_n", 64'(q_count), 64'd2);
    tick();
    chk("dual_bv1", 64'(branch_valid1), 64'd1);
    chk("dual_bv2", 64'(branch_valid2), 64'd1);
    chk("dual_pc1", branch_pc1, 64'h100);
    chk("dual_pc2", branch_pc2, 64'h104);
    chk("dual_cnt", 64'(q_count), 64'd0);

    // dual, same local index
    drive(1'b1, 64'h100, 1'b1, 1'b1, 64'h140, 1'b0, 1'b1);
    tick();
    tick();
`ifdef BP_UPD_CONFLICT_SERIALIZE_EN
    chk("conf_bv1", 64'(branch_valid1), 64'd1);
    chk("conf_pc1", branch_pc1, 64'h100);
    chk("conf_bv2", 64'(branch_valid2), 64'd0);
    chk("conf_cnt", 64'(q_count), 64'd1);
    tick();
    chk("conf_bv1_next", 64'(branch_valid1), 64'd1);
    chk("conf_pc1_next", branch_pc1, 64'h140);
    chk("conf_bv2_next", 64'(branch_valid2), 64'd0);
`else
    chk("conf_bv1", 64'(branch_valid1), 64'd1);
    chk("conf_bv2", 64'(branch_valid2), 64'd1);
    chk("conf_pc2", branch_pc2, 64'h140);
    chk("conf_cnt", 64'(q_count), 64'd0);
    tick();
    chk("conf_bv1_next", 64'(branch_valid1), 64'd0);
`endif
    chk("conf_cnt_end", 64'(q_count), 64'd0);

    // sustained two per cycle
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 64'h400 + 64'(8 * k), k[0], 1'b1, 64'h404 + 64'(8 * k), ~k[0], 1'b1);
      tick();
      chk("stream_ready", 64'(enq_ready), 64'd1);
      chk("stream_cnt", 64'(q_count), 64'd2);
      if (k > 0) chk("stream_bv2", 64'(branch_valid2), 64'd1);
    end
    tick();
    chk("stream_drain_bv2", 64'(branch_valid2), 64'd1);
    chk("stream_drain_cnt", 64'(q_count), 64'd0);

    // lone port 2
    drive(1'b0, 64'h0, 1'b0, 1'b1, 64'h208, 1'b1, 1'b1);
    tick();
    chk("lone2_cnt", 64'(q_count), 64'd1);
    tick();
    chk("lone2_bv1", 64'(branch_valid1), 64'd1);
    chk("lone2_pc1", branch_pc1, 64'h208);
    chk("lone2_bv2", 64'(branch_valid2), 64'd0);
    chk("lone2_drop", 64'(drop_err), 64'd0);

`ifdef BP_UPD_CONFLICT_SERIALIZE_EN
    // same-index pairs drain one per cycle, so the queue fills
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 64'h300 + 64'(128 * j), 1'b1, 1'b1, 64'h340 + 64'(128 * j), 1'b0, 1'b1);
      tick();
      chk("fill_cnt", 64'(q_count), 64'(j + 2));
    end
    chk("full_ready", 64'(enq_ready), 64'd0);
    drive(1'b1, 64'hDEAD0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    chk("drop_err_set", 64'(drop_err), 64'd1);
    chk("drop_cnt", 64'(q_count), 64'd6);
    tick();
    chk("drop_err_sticky", 64'(drop_err), 64'd1);
    chk("pre_flush_cnt", 64'(q_count), 64'd5);
`else
    drive(1'b1, 64'h600, 1'b0, 1'b1, 64'h604, 1'b1, 1'b1);
    tick();
    chk("pre_flush_cnt", 64'(q_count), 64'd2);
`endif
    flush = 1'b1;
    drive(1'b1, 64'h500, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    tick();
    sb.delete();
    chk("flush_cnt", 64'(q_count), 64'd0);
    chk("flush_bv1", 64'(branch_valid1), 64'd0);
    chk("flush_bv2", 64'(branch_valid2), 64'd0);
    chk("flush_drop", 64'(drop_err), 64'd0);
    chk("flush_ready", 64'(enq_ready), 64'd1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("post_flush_bv1", 64'(branch_valid1), 64'd0);
    end

    // asynchronous reset while entries are in flight
    drive(1'b1, 64'h700, 1'b0, 1'b1, 64'h704, 1'b1, 1'b1);
    tick();
    drive(1'b1, 64'h708, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
    tick();
    chk("pre_rst_bv1", 64'(branch_valid1), 64'd1);
    chk("pre_rst_cnt", 64'(q_count), 64'd1);
    drive(1'b1, 64'h710, 1'b0, 1'b1, 64'h714, 1'b1, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    sb.delete();
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("post_rst_bv1", 64'(branch_valid1), 64'd0);
      chk("post_rst_cnt", 64'(q_count), 64'd0);
    end

    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
